// File: rtl/evu_pkg.sv
// Shared types for the event unit: pipeline-facing structs, event codes,
// register field indices and bit positions of the counter bank.
package evu_pkg;

    localparam int NR_COMMIT_PORTS = 2;
    localparam int NUM_EVT         = 16;

    typedef enum logic [2:0] {
        FU_NONE,
        FU_LOAD,
        FU_STORE,
        FU_ALU,
        FU_CTRL_FLOW
    } fu_t;

    typedef enum logic [3:0] {
        JAL  = 4'd0,
        JALR = 4'd1,
        ADD  = 4'd2,
        SUB  = 4'd3
    } op_t;

    typedef struct packed {
        fu_t        fu;
        op_t        op;
        logic [4:0] rd;
    } scoreboard_entry_t;

    typedef struct packed {
        logic valid;
    } exception_t;

    typedef struct packed {
        logic valid;
        logic is_mispredict;
    } bp_resolve_t;

    typedef enum logic [3:0] {
        EVT_NONE        = 4'd0,
        EVT_CYCLES      = 4'd1,
        EVT_ICACHE_MISS = 4'd2,
        EVT_DCACHE_MISS = 4'd3,
        EVT_ITLB_MISS   = 4'd4,
        EVT_DTLB_MISS   = 4'd5,
        EVT_LOAD        = 4'd6,
        EVT_STORE       = 4'd7,
        EVT_EXCEPTION   = 4'd8,
        EVT_ERET        = 4'd9,
        EVT_BRANCH      = 4'd10,
        EVT_CALL        = 4'd11,
        EVT_RETURN      = 4'd12,
        EVT_MISPREDICT  = 4'd13,
        EVT_SB_FULL     = 4'd14,
        EVT_IF_EMPTY    = 4'd15
    } evu_event_e;

    localparam logic [1:0] FLD_CTRL   = 2'd0;
    localparam logic [1:0] FLD_COUNT  = 2'd1;
    localparam logic [1:0] FLD_THRESH = 2'd2;
    localparam logic [1:0] FLD_STATUS = 2'd3;

    localparam int CTRL_EN_BIT    = 4;
    localparam int STATUS_OVF_BIT = 0;
    localparam int STATUS_IRQ_BIT = 1;

endpackage

// File: rtl/evu_event_decode.sv
// Decodes raw pipeline events once per cycle into a registered vector of
// per-code increments shared by every counter channel.
module evu_event_decode
    import evu_pkg::*;
#(
    parameter int INC_W = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_i,
    input  logic [NR_COMMIT_PORTS-1:0]             commit_ack_i,
    input  logic                                   l1_icache_miss_i,
    input  logic                                   l1_dcache_miss_i,
    input  logic                                   itlb_miss_i,
    input  logic                                   dtlb_miss_i,
    input  logic                                   sb_full_i,
    input  logic                                   if_empty_i,
    input  logic                                   eret_i,
    input  exception_t                             ex_i,
    input  bp_resolve_t                            resolved_branch_i,
    input  logic                                   debug_mode_i,
    output logic [NUM_EVT-1:0][INC_W-1:0]          inc_q
);

    logic [NUM_EVT-1:0][INC_W-1:0] inc_d;
    logic                          is_link;

    always_comb begin
        inc_d   = '0;
        is_link = 1'b0;
        if (!debug_mode_i) begin
            inc_d[EVT_CYCLES]      = INC_W'(1);
            inc_d[EVT_ICACHE_MISS] = INC_W'(l1_icache_miss_i);
            inc_d[EVT_DCACHE_MISS] = INC_W'(l1_dcache_miss_i);
            inc_d[EVT_ITLB_MISS]   = INC_W'(itlb_miss_i);
            inc_d[EVT_DTLB_MISS]   = INC_W'(dtlb_miss_i);
            inc_d[EVT_EXCEPTION]   = INC_W'(ex_i.valid);
            inc_d[EVT_ERET]        = INC_W'(eret_i);
            inc_d[EVT_MISPREDICT]  = INC_W'(resolved_branch_i.valid && resolved_branch_i.is_mispredict);
            inc_d[EVT_SB_FULL]     = INC_W'(sb_full_i);
            inc_d[EVT_IF_EMPTY]    = INC_W'(if_empty_i);
            // Commit-side codes count matching acked ports, so several can land per cycle.
            for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
                if (commit_ack_i[p]) begin
                    is_link = (commit_instr_i[p].rd == 5'd1) || (commit_instr_i[p].rd == 5'd5);
                    if (commit_instr_i[p].fu == FU_LOAD)
                        inc_d[EVT_LOAD] = inc_d[EVT_LOAD] + INC_W'(1);
                    if (commit_instr_i[p].fu == FU_STORE)
                        inc_d[EVT_STORE] = inc_d[EVT_STORE] + INC_W'(1);
                    if (commit_instr_i[p].fu == FU_CTRL_FLOW)
                        inc_d[EVT_BRANCH] = inc_d[EVT_BRANCH] + INC_W'(1);
                    if ((commit_instr_i[p].fu == FU_CTRL_FLOW) && is_link &&
                        ((commit_instr_i[p].op == JAL) || (commit_instr_i[p].op == JALR)))
                        inc_d[EVT_CALL] = inc_d[EVT_CALL] + INC_W'(1);
                    if ((commit_instr_i[p].op == JALR) && (commit_instr_i[p].rd == 5'd0))
                        inc_d[EVT_RETURN] = inc_d[EVT_RETURN] + INC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) inc_q <= '0;
        else       inc_q <= inc_d;
    end

endmodule

// File: rtl/evu_counter_bank.sv
// Bank of NUM_CH programmable event counters with overflow and threshold
// interrupt, configured through a small address/data register port.
module evu_counter_bank
    import evu_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_i,
    input  logic [NR_COMMIT_PORTS-1:0]             commit_ack_i,
    input  logic                                   l1_icache_miss_i,
    input  logic                                   l1_dcache_miss_i,
    input  logic                                   itlb_miss_i,
    input  logic                                   dtlb_miss_i,
    input  logic                                   sb_full_i,
    input  logic                                   if_empty_i,
    input  logic                                   eret_i,
    input  exception_t                             ex_i,
    input  bp_resolve_t                            resolved_branch_i,
    input  logic                                   debug_mode_i,
    input  logic                                   cfg_we_i,
    input  logic [$clog2(NUM_CH)+1:0]              cfg_addr_i,
    input  logic [CNT_W-1:0]                       cfg_wdata_i,
    output logic [CNT_W-1:0]                       cfg_rdata_o,
    output logic [NUM_CH-1:0]                      evt_o,
    output logic [NUM_CH-1:0]                      irq_o
);

    localparam int INC_W = $clog2(NR_COMMIT_PORTS + 1);
    localparam int AW    = $clog2(NUM_CH) + 2;

    logic [NUM_EVT-1:0][INC_W-1:0] inc_q;
    logic [AW-1:0]                 addr_ch;
    logic [1:0]                    addr_fld;
    logic [CNT_W-1:0]              rd_ctrl   [NUM_CH];
    logic [CNT_W-1:0]              rd_count  [NUM_CH];
    logic [CNT_W-1:0]              rd_thresh [NUM_CH];
    logic [CNT_W-1:0]              rd_status [NUM_CH];

    assign addr_ch  = cfg_addr_i >> 2;
    assign addr_fld = cfg_addr_i[1:0];

    evu_event_decode #(.INC_W(INC_W)) u_decode (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .commit_instr_i    (commit_instr_i),
        .commit_ack_i      (commit_ack_i),
        .l1_icache_miss_i  (l1_icache_miss_i),
        .l1_dcache_miss_i  (l1_dcache_miss_i),
        .itlb_miss_i       (itlb_miss_i),
        .dtlb_miss_i       (dtlb_miss_i),
        .sb_full_i         (sb_full_i),
        .if_empty_i        (if_empty_i),
        .eret_i            (eret_i),
        .ex_i              (ex_i),
        .resolved_branch_i (resolved_branch_i),
        .debug_mode_i      (debug_mode_i),
        .inc_q             (inc_q)
    );

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic             en_q;
        logic [3:0]       sel_q;
        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] thresh_q;
        logic             ovf_q;
        logic             irq_q;
        logic             evt_q;
        logic [INC_W-1:0] inc;
        logic [CNT_W:0]   sum;
        logic             hit_ch;
        logic             wr_ctrl, wr_count, wr_thresh, wr_status;
        logic             applied;
        logic             carry;
        logic             irq_set;

        assign hit_ch    = cfg_we_i && (addr_ch == AW'(ch));
        assign wr_ctrl   = hit_ch && (addr_fld == FLD_CTRL);
        assign wr_count  = hit_ch && (addr_fld == FLD_COUNT);
        assign wr_thresh = hit_ch && (addr_fld == FLD_THRESH);
        assign wr_status = hit_ch && (addr_fld == FLD_STATUS);

        assign inc     = en_q ? inc_q[sel_q] : '0;
        assign sum     = {1'b0, count_q} + {{(CNT_W + 1 - INC_W){1'b0}}, inc};
        // A software COUNT write in the same cycle discards the increment entirely.
        assign applied = (inc != '0) && !wr_count;
        assign carry   = applied && sum[CNT_W];
        assign irq_set = applied && (sum[CNT_W-1:0] >= thresh_q) &&
                         ((count_q < thresh_q) || sum[CNT_W]);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                en_q     <= 1'b0;
                sel_q    <= 4'd0;
                count_q  <= '0;
                thresh_q <= '1;
                ovf_q    <= 1'b0;
                irq_q    <= 1'b0;
                evt_q    <= 1'b0;
            end else begin
                if (wr_ctrl) begin
                    en_q  <= cfg_wdata_i[CTRL_EN_BIT];
                    sel_q <= cfg_wdata_i[3:0];
                end
                if (wr_count)     count_q <= cfg_wdata_i;
                else if (applied) count_q <= sum[CNT_W-1:0];
                if (wr_thresh) thresh_q <= cfg_wdata_i;
                ovf_q <= (ovf_q & ~(wr_status & cfg_wdata_i[STATUS_OVF_BIT])) | carry;
                irq_q <= (irq_q & ~(wr_status & cfg_wdata_i[STATUS_IRQ_BIT])) | irq_set;
                evt_q <= (inc != '0);
            end
        end

        assign rd_ctrl[ch]   = CNT_W'({en_q, sel_q});
        assign rd_count[ch]  = count_q;
        assign rd_thresh[ch] = thresh_q;
        assign rd_status[ch] = CNT_W'({irq_q, ovf_q});
        assign evt_o[ch]     = evt_q;
        assign irq_o[ch]     = irq_q;
    end

    always_comb begin
        cfg_rdata_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (addr_ch == AW'(c)) begin
                case (addr_fld)
                    FLD_CTRL:   cfg_rdata_o = rd_ctrl[c];
                    FLD_COUNT:  cfg_rdata_o = rd_count[c];
                    FLD_THRESH: cfg_rdata_o = rd_thresh[c];
                    default:    cfg_rdata_o = rd_status[c];
                endcase
            end
        end
    end

endmodule
